branch_operand_scoreboard: RTL

// - Producer side of the ID-stage branch comparator: decides when both compare operands are valid
//   and where each one comes from, so that beq/bne resolve in ID.
// - Tracks in-flight register writes in a 3-slot shift register mirroring E/M/W.
// - Per operand, selects register file or a forwarding stage, or asserts stall until the value exists.
// - Sits between the decoder (issue info) and the ID forwarding muxes feeding the comparator.
//

---
 rtl/branch_operand_scoreboard_if.sv | 30 +++
 rtl/branch_operand_scoreboard.sv | 128 ++++++++++++
 2 files changed

// File: rtl/branch_operand_scoreboard_if.sv
// Operand-lookup handshake between the ID decoder and the branch operand scoreboard.
// The decoder side uses the master modport; the scoreboard uses the slave modport.
interface branch_operand_scoreboard_if #(
   parameter int TNEW_W = 2
);
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic              issue_we;
   logic [4:0]        issue_rd;
   logic [TNEW_W-1:0] issue_tnew;
   logic              hold;
   logic              flush;
   logic              stall;
   logic [1:0]        fwd_sel_rs;
   logic [1:0]        fwd_sel_rt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
      output issue_we, issue_rd, issue_tnew, hold, flush,
      input  stall, fwd_sel_rs, fwd_sel_rt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
      input  issue_we, issue_rd, issue_tnew, hold, flush,
      output stall, fwd_sel_rs, fwd_sel_rt
   );
endinterface

// File: rtl/branch_operand_scoreboard.sv
// ID-stage branch operand scoreboard: tracks E/M/W producers and picks forward source or stall.
// Optional feature macro: CMP_STALL_STATS_EN adds the stall_cycles counter output.
module branch_operand_scoreboard #(
   parameter int TNEW_W = 2
) (
   input  logic clk,
   input  logic reset,
   branch_operand_scoreboard_if.slave bus
`ifdef CMP_STALL_STATS_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   // slot index 0 = E, 1 = M, 2 = W
   logic [2:0]        slot_valid_r;
   logic [4:0]        slot_rd_r   [3];
   logic [TNEW_W-1:0] slot_tnew_r [3];

   logic [14:0]         rd_flat_s;
   logic [3*TNEW_W-1:0] tnew_flat_s;
   logic [2:0]          rs_res_s;
   logic [2:0]          rt_res_s;
   logic                stall_s;
   logic                accept_s;
   logic                e_valid_s;
   logic [4:0]          e_rd_s;
   logic [TNEW_W-1:0]   e_tnew_s;

   // Youngest matching producer wins; result is {pending, fwd_sel}.
   function automatic logic [2:0] resolve(
      input logic                use_op,
      input logic [4:0]          r,
      input logic [2:0]          v,
      input logic [14:0]         rds,
      input logic [3*TNEW_W-1:0] tns
   );
      logic       found;
      logic [2:0] res;
      found = 1'b0;
      res   = 3'b000;
      if (use_op && (r != 5'd0)) begin
         for (int i = 0; i < 3; i++) begin
            if (!found && v[i] && (rds[i*5 +: 5] == r)) begin
               found = 1'b1;
               if (tns[i*TNEW_W +: TNEW_W] != {TNEW_W{1'b0}}) begin
                  res = 3'b100;
               end else begin
                  res = {1'b0, 2'(i + 1)};
               end
            end else begin
               res = res;
            end
         end
      end else begin
         res = 3'b000;
      end
      return res;
   endfunction

   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
      return (t == {TNEW_W{1'b0}}) ? {TNEW_W{1'b0}} : (t - {{(TNEW_W-1){1'b0}}, 1'b1});
   endfunction

   assign rd_flat_s   = {slot_rd_r[2], slot_rd_r[1], slot_rd_r[0]};
   assign tnew_flat_s = {slot_tnew_r[2], slot_tnew_r[1], slot_tnew_r[0]};

   // Operand lookup against in-flight producers and the resulting stall.
   always_comb begin
      rs_res_s = resolve(bus.id_use_rs, bus.id_rs, slot_valid_r, rd_flat_s, tnew_flat_s);
      rt_res_s = resolve(bus.id_use_rt, bus.id_rt, slot_valid_r, rd_flat_s, tnew_flat_s);
      stall_s  = rs_res_s[2] | rt_res_s[2];
   end

   // Entry for E: the ID instruction when it advances, otherwise a bubble.
   always_comb begin
      accept_s  = ~stall_s & ~bus.flush;
      e_valid_s = 1'b0;
      e_rd_s    = 5'd0;
      e_tnew_s  = {TNEW_W{1'b0}};
      if (accept_s) begin
         e_valid_s = bus.issue_we & (bus.issue_rd != 5'd0);
         e_rd_s    = bus.issue_rd;
         e_tnew_s  = bus.issue_tnew;
      end else begin
         e_valid_s = 1'b0;
      end
   end

   assign bus.stall      = stall_s;
   assign bus.fwd_sel_rs = rs_res_s[1:0];
   assign bus.fwd_sel_rt = rt_res_s[1:0];

   // Slot shift register: reset clears, hold freezes, otherwise advance one stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid_r <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            slot_rd_r[i]   <= 5'd0;
            slot_tnew_r[i] <= {TNEW_W{1'b0}};
         end
      end else if (bus.hold) begin
         slot_valid_r <= slot_valid_r;
      end else begin
         slot_valid_r   <= {slot_valid_r[1:0], e_valid_s};
         slot_rd_r[2]   <= slot_rd_r[1];
         slot_rd_r[1]   <= slot_rd_r[0];
         slot_rd_r[0]   <= e_rd_s;
         slot_tnew_r[2] <= sat_dec(slot_tnew_r[1]);
         slot_tnew_r[1] <= sat_dec(slot_tnew_r[0]);
         slot_tnew_r[0] <= e_tnew_s;
      end
   end

`ifdef CMP_STALL_STATS_EN
   // Count cycles the branch actually waits (frozen cycles are not charged).
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= 32'd0;
      end else if (stall_s && !bus.hold) begin
         stall_cycles <= stall_cycles + 32'd1;
      end else begin
         stall_cycles <= stall_cycles;
      end
   end
`endif

endmodule
